// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel integer clock divider:
// per-channel state encoding and the default division-factor width.
package clock_div_pkg;

  localparam int DEFAULT_DIV_WIDTH = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, shadow divider and IDLE/RUN FSM.
// The live div/en inputs are only looked at when a period starts or on sync.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 en,
  input  logic                 sync,
  output logic                 clk_out,
  output logic                 stb,
  output chan_state_e          state
);

  chan_state_e          state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] n_act_q, n_act_d;
  logic                 clk_out_q, clk_out_d;
  logic                 stb_q, stb_d;

  logic                 start_ok;
  logic                 period_end;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [DIV_WIDTH-1:0] n_last;

  always_comb begin
    start_ok   = en && (div != '0);
    cnt_inc    = cnt_q + 1'b1;
    n_last     = n_act_q - 1'b1;
    period_end = (state_q == ST_RUN) && (cnt_q == n_last);

    state_d   = state_q;
    cnt_d     = cnt_q;
    n_act_d   = n_act_q;
    clk_out_d = clk_out_q;
    stb_d     = 1'b0;

    // sync, an idle channel and the last cycle of a period all resolve the same way
    if (sync || (state_q == ST_IDLE) || period_end) begin
      if (start_ok) begin
        state_d   = ST_RUN;
        cnt_d     = '0;
        n_act_d   = div;
        clk_out_d = ((div >> 1) != '0);
        stb_d     = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        n_act_d   = '0;
        clk_out_d = 1'b0;
      end
    end else begin
      cnt_d     = cnt_inc;
      clk_out_d = (cnt_inc < (n_act_q >> 1));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      n_act_q   <= '0;
      clk_out_q <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_act_q   <= n_act_d;
      clk_out_q <= clk_out_d;
      stb_q     <= stb_d;
    end
  end

  assign clk_out = clk_out_q;
  assign stb     = stb_q;
  assign state   = state_q;

endmodule

// File: rtl/clock_div_multi.sv
// NCH independent integer clock dividers sharing reset and a phase-align sync.
// Each channel's FSM state flop drives its active bit directly.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NCH*DIV_WIDTH-1:0] div,
  input  logic [NCH-1:0]           en,
  input  logic                     sync,
  output logic [NCH-1:0]           clk_out,
  output logic [NCH-1:0]           stb,
  output logic [NCH-1:0]           active
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    chan_state_e st;

    clock_div_chan #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .div     (div[k*DIV_WIDTH +: DIV_WIDTH]),
      .en      (en[k]),
      .sync    (sync),
      .clk_out (clk_out[k]),
      .stb     (stb[k]),
      .state   (st)
    );

    assign active[k] = (st == ST_RUN);
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi: each scenario drives div/en/sync and
// compares outputs cycle by cycle against hand-derived waveforms.
module tb_clock_div_multi;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic                clk_in;
  logic                rst;
  logic [NCH*DW-1:0]   div;
  logic [NCH-1:0]      en;
  logic                sync;
  logic [NCH-1:0]      clk_out;
  logic [NCH-1:0]      stb;
  logic [NCH-1:0]      active;

  int n_cmp;
  int n_err;
  logic [1:0] exp_q[$];

  clock_div_multi #(
    .NCH       (NCH),
    .DIV_WIDTH (DW)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .div     (div),
    .en      (en),
    .sync    (sync),
    .clk_out (clk_out),
    .stb     (stb),
    .active  (active)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // outputs are sampled 1 time unit after the active edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_div(input int k, input int v);
    div[k*DW +: DW] = v[DW-1:0];
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = '0;
    sync = 1'b0;
    div  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int s3_clk[14] = '{1,1,1,1,0,0,0,0,1,0,0,1,0,0};
    int s3_stb[14] = '{1,0,0,0,0,0,0,0,1,0,0,1,0,0};
    int s1_clk[6]  = '{1,1,0,0,0,1};
    int s1_stb[6]  = '{1,0,0,0,0,1};
    logic [1:0] e;
    logic [NCH-1:0] e_clk, e_stb;

    n_cmp = 0;
    n_err = 0;

    // reset state
    do_reset();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_stb", 32'(stb), 32'h0);
    check("rst_active", 32'(active), 32'h0);

    // N=5 on channel 0: 2 high / 3 low, stb at t+1 and t+6
    set_div(0, 5);
    en = 4'b0001;
    for (int i = 0; i < 6; i++) exp_q.push_back({s1_clk[i][0], s1_stb[i][0]});
    tick();
    check("s1_active", 32'(active), 32'h1);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      check($sformatf("s1_clk_%0d", i), 32'(clk_out[0]), 32'(e[1]));
      check($sformatf("s1_stb_%0d", i), 32'(stb[0]), 32'(e[0]));
      tick();
    end

    // N=2,3,4,1 on four channels
    do_reset();
    set_div(0, 2);
    set_div(1, 3);
    set_div(2, 4);
    set_div(3, 1);
    en = 4'b1111;
    tick();
    for (int i = 0; i < 12; i++) begin
      e_clk = {1'b0, (i % 4) < 2, (i % 3) == 0, (i % 2) == 0};
      e_stb = {1'b1, (i % 4) == 0, (i % 3) == 0, (i % 2) == 0};
      check($sformatf("s2_clk_%0d", i), 32'(clk_out), 32'(e_clk));
      check($sformatf("s2_stb_%0d", i), 32'(stb), 32'(e_stb));
      tick();
    end

    // N=0 never leaves IDLE
    do_reset();
    set_div(0, 0);
    en = 4'b0001;
    tick();
    tick();
    tick();
    check("s2_n0_active", 32'(active), 32'h0);
    check("s2_n0_clk", 32'(clk_out), 32'h0);
    check("s2_n0_stb", 32'(stb), 32'h0);

    // div 8 -> 3 mid-period: current period kept, next one shortened
    do_reset();
    set_div(0, 8);
    en = 4'b0001;
    for (int i = 0; i < 14; i++) exp_q.push_back({s3_clk[i][0], s3_stb[i][0]});
    tick();
    for (int i = 0; i < 14; i++) begin
      e = exp_q.pop_front();
      check($sformatf("s3_clk_%0d", i), 32'(clk_out[0]), 32'(e[1]));
      check($sformatf("s3_stb_%0d", i), 32'(stb[0]), 32'(e[0]));
      if (i == 1) set_div(0, 3);
      tick();
    end

    // en[1] dropped during high phase of N=10: period completes, then idle
    do_reset();
    set_div(1, 10);
    en = 4'b0010;
    tick();
    for (int i = 0; i < 13; i++) begin
      check($sformatf("s4_clk_%0d", i), 32'(clk_out[1]), 32'(i < 5));
      check($sformatf("s4_act_%0d", i), 32'(active[1]), 32'(i < 10));
      if (i == 1) en = 4'b0000;
      tick();
    end

    // sync realigns N=6 and N=9 channels
    do_reset();
    set_div(0, 6);
    set_div(1, 9);
    en = 4'b0001;
    tick();
    tick();
    en = 4'b0011;
    for (int i = 0; i < 5; i++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int i = 0; i <= 18; i++) begin
      e_stb = {2'b00, (i % 9) == 0, (i % 6) == 0};
      e_clk = {2'b00, (i % 9) < 4, (i % 6) < 3};
      check($sformatf("s5_stb_%0d", i), 32'(stb), 32'(e_stb));
      check($sformatf("s5_clk_%0d", i), 32'(clk_out), 32'(e_clk));
      tick();
    end

    // rst beats sync mid-period; restart latency matches a fresh start
    do_reset();
    set_div(0, 5);
    set_div(1, 6);
    set_div(2, 7);
    set_div(3, 8);
    en = 4'b1111;
    tick();
    tick();
    tick();
    rst  = 1'b1;
    sync = 1'b1;
    tick();
    check("s6_rst_clk", 32'(clk_out), 32'h0);
    check("s6_rst_stb", 32'(stb), 32'h0);
    check("s6_rst_act", 32'(active), 32'h0);
    rst  = 1'b0;
    sync = 1'b0;
    tick();
    check("s6_re_clk", 32'(clk_out), 32'hf);
    check("s6_re_stb", 32'(stb), 32'hf);
    check("s6_re_act", 32'(active), 32'hf);
    tick();
    check("s6_re2_clk", 32'(clk_out), 32'hf);
    check("s6_re2_stb", 32'(stb), 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
